operand_mux_pipe: RTL
=====================

// Module: operand_mux_pipe
//
// PURPOSE
//   Parametrised, registered N-way operand selector for the Simple CPU datapath.
//   Supersedes the 2:1 ACC/PC combinational mux.
//   Selects one of NUM_IN WIDTH-bit channels and registers the result.
//   A valid/ready handshake with a 2-entry skid buffer lets the ALU stage
//   stall without dropping operands.
//
// PARAMETERS
//   WIDTH   8  data width of each channel and of out_data
//   NUM_IN  2  number of input channels (>=2); ch0 = ACC, ch1 = PC in the v1 map
//   SEL_W   localparam = max(1,$clog2(NUM_IN)); width of sel
//
// PORTS
//   clk       in   1             rising-edge clock
//   rst       in   1             reset; synchronous, active-high
//   in_bus    in   NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   sel       in   SEL_W         channel index, sampled with in_valid
//   in_valid  in   1             upstream offers {in_bus,sel}
//   in_ready  out  1             block can accept this cycle
//   out_data  out  WIDTH         selected operand
//   out_err   out  1             beat was captured with sel >= NUM_IN
//   out_par   out  1             even parity of out_data (see CONFIGURATION)
//   out_valid out  1             out_data/out_err/out_par valid
//   out_ready in   1             downstream accepts this cycle
//
// BEHAVIOUR
// - Registers driven by clk only. While rst=1 at a clock edge:
//   out_valid=0, out_data=0, out_err=0, out_par=0, skid emptied,
//   so in_ready=1 from the next cycle. Reset mid-transfer discards both entries.
// - Accept event: in_valid & in_ready. Deliver event: out_valid & out_ready.
// - in_ready = ~skid_valid (registered state, no comb path from out_ready).
// - Latency: accepted beat appears on out_* the next cycle if the output register is free.
// - States:
//   - EMPTY: out_valid=0, skid empty.
//   - ONE: out_valid=1, skid empty.
//   - FULL: out_valid=1, skid held, in_ready=0.
// - Transitions:
//   - EMPTY + accept -> ONE
//   - ONE: accept & deliver -> ONE (out reg reloaded)
//   - ONE: accept & ~deliver -> FULL (beat to skid)
//   - ONE: ~accept & deliver -> EMPTY
//   - ONE: neither -> hold
//   - FULL: deliver -> ONE (skid moves to out reg, same edge). No accept possible.
//   - FULL: ~deliver -> hold
// - While out_valid=1 & ~out_ready, out_* are stable (no change until delivered).
// - Ordering strictly FIFO; no beat is dropped or duplicated.
// - Select: data = in_bus[sel*WIDTH +: WIDTH] when sel < NUM_IN.
//   Otherwise data = 0 and err = 1, carried with the beat.
//   Non-power-of-2 NUM_IN must hit this path.
// - in_bus/sel are ignored when no accept occurs.
//
// CONFIGURATION
//   OPMUX_PARITY_EN defined:
//     par = ^data computed at capture and carried with the beat through skid/out.
//     An err beat has par=0.
//   OPMUX_PARITY_EN undefined:
//     out_par tied to 0, no parity storage; all else identical.
//
// TESTING
//   T1 Reset: rst=1 for 2 cycles with in_valid=1
//      -> out_valid=0, out_data=0; in_ready=1 the cycle after rst falls.
//   T2 Basic: NUM_IN=2, WIDTH=8, ch0=8'h3C, ch1=8'hA5, sel=1, in_valid 1 cycle, out_ready=1
//      -> next cycle out_valid=1, out_data=8'hA5, out_err=0, then out_valid=0.
//   T3 Stall: out_ready=0, send beats 8'h11, 8'h22
//      -> in_ready=0 after 2nd accept; 3rd offer 8'h33 held off.
//      Raise out_ready -> 11, 22, 33 delivered in order, no gaps beyond 1 refill.
//   T4 Out of range: NUM_IN=3, WIDTH=8, sel=3
//      -> out_data=0, out_err=1; next beat sel=2 (ch2=8'h7E) -> out_err=0, out_data=8'h7E.
//   T5 Streaming: in_valid=1, out_ready=1 every cycle for 16 beats
//      -> 16 deliveries in 16 consecutive cycles after 1-cycle latency.
//   T6 Mid-op reset: FULL state, assert rst
//      -> both entries lost, out_valid=0 next cycle.
//      With OPMUX_PARITY_EN: 8'h07 -> out_par=1.

Source files
------------

// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe: registered NUM_IN-way operand selector with a valid/ready
// handshake and a one-entry skid register behind the output register, giving
// two beats of storage so the ALU stage can stall without losing operands.
//
// Optional feature macro: OPMUX_PARITY_EN
//   defined   -> even parity of the selected data is computed at capture and
//                carried with the beat through skid and output registers.
//   undefined -> out_par is tied to 0 and no parity storage exists.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_bus     NUM_IN*WIDTH channels, channel k at [k*WIDTH +: WIDTH]
//   sel        channel index, sampled on accept
//   in_valid   upstream offers {in_bus, sel}
//   in_ready   block can accept this cycle (skid register empty)
//   out_data   selected operand
//   out_err    beat was captured with sel >= NUM_IN (data forced to 0)
//   out_par    even parity of out_data (0 when parity is disabled)
//   out_valid  out_data/out_err/out_par valid
//   out_ready  downstream accepts this cycle
module operand_mux_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2,
  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_par,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             accept;
  logic             deliver;
  logic             load_out;
  logic             load_skid;
  logic             unload_skid;

  logic [WIDTH-1:0] cap_data;
  logic             cap_hit;
  logic             cap_err;

  logic [WIDTH-1:0] skid_data;
  logic             skid_err;

  // Handshake events decoded straight from state so in_ready never depends on out_ready.
  assign accept  = in_valid  & (state != S_FULL);
  assign deliver = out_ready & (state != S_EMPTY);

  // Channel select; any sel without a matching channel yields data 0 and err 1.
  always_comb begin
    cap_data = '0;
    cap_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        cap_data = in_bus[k*WIDTH +: WIDTH];
        cap_hit  = 1'b1;
      end
    end
  end

  assign cap_err = ~cap_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_EMPTY: begin
        if (accept) state_nxt = S_ONE;
      end
      S_ONE: begin
        if (accept && !deliver)      state_nxt = S_FULL;
        else if (!accept && deliver) state_nxt = S_EMPTY;
      end
      S_FULL: begin
        if (deliver) state_nxt = S_ONE;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Output / datapath-control decode.
  always_comb begin
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    unload_skid = 1'b0;
    unique case (state)
      S_EMPTY: begin
        load_out = accept;
      end
      S_ONE: begin
        out_valid = 1'b1;
        load_out  = accept & deliver;
        load_skid = accept & ~deliver;
      end
      S_FULL: begin
        in_ready    = 1'b0;
        out_valid   = 1'b1;
        unload_skid = deliver;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  // Output and skid registers; the skid beat moves forward on the same edge it is freed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_out) begin
        out_data <= cap_data;
        out_err  <= cap_err;
      end else if (unload_skid) begin
        out_data <= skid_data;
        out_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= cap_data;
        skid_err  <= cap_err;
      end
    end
  end

`ifdef OPMUX_PARITY_EN
  logic cap_par;
  logic skid_par;

  // Err beats carry zero data, so their parity is naturally 0.
  assign cap_par = ^cap_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_par  <= 1'b0;
      skid_par <= 1'b0;
    end else begin
      if (load_out) begin
        out_par <= cap_par;
      end else if (unload_skid) begin
        out_par <= skid_par;
      end
      if (load_skid) begin
        skid_par <= cap_par;
      end
    end
  end
`else
  assign out_par = 1'b0;
`endif

endmodule
